fft_radix2_iter: RTL

//  Parametrised N-point complex radix-2 DIT FFT for the audio-visualizer datapath.

---
 rtl/fft_radix2_iter.sv | 219 +++++++++++++++++++++
 1 files changed

// File: rtl/fft_radix2_iter.sv
// fft_radix2_iter: iterative in-place radix-2 DIT FFT with one shared butterfly.
// Samples land in bit-reversed order; bins stream out in natural order.
module fft_radix2_iter #(
  parameter int N_POINTS = 8,
  parameter int DATA_W   = 16,
  parameter int TW_FRAC  = 7
) (
  input  logic                        clk_i,
  input  logic                        reset_i,
  input  logic                        in_valid_i,
  output logic                        in_ready_o,
  input  logic [DATA_W-1:0]           in_re_i,
  input  logic [DATA_W-1:0]           in_im_i,
  output logic                        out_valid_o,
  input  logic                        out_ready_i,
  output logic [DATA_W-1:0]           out_re_o,
  output logic [DATA_W-1:0]           out_im_o,
  output logic [$clog2(N_POINTS)-1:0] out_index_o,
  output logic                        busy_o,
  output logic                        done_o
);

  localparam int LW   = $clog2(N_POINTS);
  localparam int HALF = N_POINTS / 2;
  localparam int CW   = TW_FRAC + 2;
  localparam int PW   = DATA_W + CW + 1;
  localparam int SW   = PW + 1;
  localparam int FB   = 28;
  localparam longint SCALE = 64'sd1 <<< FB;
  localparam longint PI_S  = 64'sd843314857;

  typedef enum logic [1:0] {
    S_IDLE, S_LOAD, S_CALC, S_UNLOAD
  } state_t;

  // Fixed-point Taylor series keeps the ROM build free of real arithmetic.
  function automatic longint tw_calc(input int k, input bit want_sin);
    longint th, term, acc, den;
    th   = (2 * PI_S * k) / N_POINTS;
    term = want_sin ? th : SCALE;
    acc  = term;
    for (int i = 1; i < 14; i++) begin
      den  = want_sin ? longint'((2*i) * (2*i+1))
                      : longint'((2*i-1) * (2*i));
      term = (term * th) / SCALE;
      term = (term * th) / SCALE;
      term = -term / den;
      acc  = acc + term;
    end
    if (want_sin) acc = -acc;
    return ((acc <<< TW_FRAC) + (SCALE >>> 1)) >>> FB;
  endfunction

  function automatic logic [LW-1:0] bitrev(input logic [LW-1:0] x);
    logic [LW-1:0] r;
    r = '0;
    for (int i = 0; i < LW; i++) r[i] = x[LW-1-i];
    return r;
  endfunction

  function automatic logic [DATA_W-1:0] sat(input logic signed [SW-1:0] x);
    logic signed [SW-1:0] hi, lo;
    hi = SW'({1'b0, {(DATA_W-1){1'b1}}});
    lo = ~hi;
    if (x > hi)      return hi[DATA_W-1:0];
    else if (x < lo) return lo[DATA_W-1:0];
    else             return x[DATA_W-1:0];
  endfunction

  logic signed [CW-1:0] tw_re [HALF];
  logic signed [CW-1:0] tw_im [HALF];

  for (genvar g = 0; g < HALF; g++) begin : g_tw
    localparam logic signed [CW-1:0] WR = CW'(tw_calc(g, 1'b0));
    localparam logic signed [CW-1:0] WI = CW'(tw_calc(g, 1'b1));
    assign tw_re[g] = WR;
    assign tw_im[g] = WI;
  end

  logic signed [DATA_W-1:0] mem_re [N_POINTS];
  logic signed [DATA_W-1:0] mem_im [N_POINTS];

  state_t            state_q, state_d;
  logic [LW-1:0]     cnt_q, cnt_d;
  logic [LW-2:0]     bf_q, bf_d;
  logic [LW-1:0]     st_q, st_d;
  logic              ov_q, ov_d;
  logic [DATA_W-1:0] ore_q, ore_d;
  logic [DATA_W-1:0] oim_q, oim_d;
  logic              done_q, done_d;

  logic [LW-1:0] bx, span, lo_mask, a_addr, b_addr;
  logic [LW-2:0] k_idx;

  // Butterfly b of stage st: insert a zero at bit st to get the A address.
  always_comb begin
    span    = LW'(1) << st_q;
    lo_mask = span - LW'(1);
    bx      = {1'b0, bf_q};
    a_addr  = ((bx & ~lo_mask) << 1) | (bx & lo_mask);
    b_addr  = a_addr | span;
    k_idx   = (LW-1)'((bx & lo_mask) << (LW - 1 - int'(st_q)));
  end

  logic signed [DATA_W-1:0] a_re, a_im, b_re, b_im;
  logic signed [CW-1:0]     w_re, w_im;
  logic signed [PW-1:0]     t_re, t_im;
  logic signed [SW-1:0]     s_re, s_im, d_re, d_im;

  always_comb begin
    a_re = mem_re[a_addr];
    a_im = mem_im[a_addr];
    b_re = mem_re[b_addr];
    b_im = mem_im[b_addr];
    w_re = tw_re[k_idx];
    w_im = tw_im[k_idx];
    t_re = (PW'(b_re) * PW'(w_re) - PW'(b_im) * PW'(w_im)) >>> TW_FRAC;
    t_im = (PW'(b_re) * PW'(w_im) + PW'(b_im) * PW'(w_re)) >>> TW_FRAC;
    s_re = (SW'(a_re) + SW'(t_re)) >>> 1;
    s_im = (SW'(a_im) + SW'(t_im)) >>> 1;
    d_re = (SW'(a_re) - SW'(t_re)) >>> 1;
    d_im = (SW'(a_im) - SW'(t_im)) >>> 1;
  end

  logic ld_fire, out_fire;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bf_d    = bf_q;
    st_d    = st_q;
    ov_d    = ov_q;
    ore_d   = ore_q;
    oim_d   = oim_q;
    done_d  = 1'b0;
    ld_fire  = in_valid_i &&
               (state_q == S_IDLE || state_q == S_LOAD);
    out_fire = ov_q && out_ready_i;
    unique case (state_q)
      S_IDLE, S_LOAD: begin
        if (ld_fire) begin
          cnt_d   = cnt_q + LW'(1);
          state_d = (cnt_q == LW'(N_POINTS - 1)) ? S_CALC : S_LOAD;
        end
      end
      S_CALC: begin
        bf_d = bf_q + (LW-1)'(1);
        if (bf_q == (LW-1)'(HALF - 1)) begin
          st_d = st_q + LW'(1);
          if (st_q == LW'(LW - 1)) begin
            st_d    = '0;
            state_d = S_UNLOAD;
          end
        end
      end
      S_UNLOAD: begin
        // Output registers add the one-cycle gap before the first bin.
        if (!ov_q) begin
          ov_d  = 1'b1;
          ore_d = mem_re[cnt_q];
          oim_d = mem_im[cnt_q];
        end else if (out_fire) begin
          cnt_d = cnt_q + LW'(1);
          ore_d = mem_re[cnt_d];
          oim_d = mem_im[cnt_d];
          if (cnt_q == LW'(N_POINTS - 1)) begin
            ov_d    = 1'b0;
            done_d  = 1'b1;
            state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      bf_q    <= '0;
      st_q    <= '0;
      ov_q    <= 1'b0;
      ore_q   <= '0;
      oim_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bf_q    <= bf_d;
      st_q    <= st_d;
      ov_q    <= ov_d;
      ore_q   <= ore_d;
      oim_q   <= oim_d;
      done_q  <= done_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (ld_fire) begin
      mem_re[bitrev(cnt_q)] <= in_re_i;
      mem_im[bitrev(cnt_q)] <= in_im_i;
    end else if (state_q == S_CALC) begin
      mem_re[a_addr] <= sat(s_re);
      mem_im[a_addr] <= sat(s_im);
      mem_re[b_addr] <= sat(d_re);
      mem_im[b_addr] <= sat(d_im);
    end
  end

  assign in_ready_o  = (state_q == S_IDLE) || (state_q == S_LOAD);
  assign busy_o      = (state_q == S_CALC) || (state_q == S_UNLOAD);
  assign out_valid_o = ov_q;
  assign out_re_o    = ore_q;
  assign out_im_o    = oim_q;
  assign out_index_o = (state_q == S_UNLOAD) ? cnt_q : '0;
  assign done_o      = done_q;

endmodule
